// File: rtl/alu_cmd_if.sv
// Command, ALU-drive and response signals of the accumulator-ALU sequencer.
// master = command source / response sink / ALU side, slave = sequencer.
interface alu_cmd_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       alu_in_sel;
  logic [WIDTH-1:0] alu_num1;
  logic [WIDTH-1:0] alu_num2;
  logic [6:0]       alu_out_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b, rsp_ready, alu_result, alu_overflow,
    input  cmd_ready, alu_in_sel, alu_num1, alu_num2, alu_out_sel, rsp_valid, rsp_data,
           rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b, rsp_ready, alu_result, alu_overflow,
    output cmd_ready, alu_in_sel, alu_num1, alu_num2, alu_out_sel, rsp_valid, rsp_data,
           rsp_err, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a small FIFO, issues them one at a time to the
// accumulator ALU, waits its fixed latency and returns result/overflow.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input logic      clk,
  input logic      rst,
  alu_cmd_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef struct packed {
    logic [2:0]       op;
    logic             load;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, CLR} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count, countNext;
  state_t        state;
  logic [CW-1:0] waitCnt;
  logic          ovfPend;
  logic          push, pop, goIdle;

  always_comb begin
    push      = bus.cmd_valid && bus.cmd_ready;
    pop       = (state == IDLE) && (count != '0);
    countNext = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    head      = mem[rdPtr];
    // FSM will sit in IDLE after this edge
    goIdle    = ((state == IDLE) && !pop) ||
                ((state == RESP) && bus.rsp_ready && !ovfPend) ||
                (state == CLR);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= '{op: bus.cmd_op, load: bus.cmd_load, a: bus.cmd_a, b: bus.cmd_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wrPtr           <= '0;
      rdPtr           <= '0;
      count           <= '0;
      waitCnt         <= '0;
      ovfPend         <= 1'b0;
      bus.cmd_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
      bus.alu_in_sel  <= 3'b001;
      bus.alu_num1    <= '0;
      bus.alu_num2    <= '0;
      bus.alu_out_sel <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count          <= countNext;
      bus.cmd_ready  <= (countNext < (AW+1)'(DEPTH));
      bus.busy       <= (countNext != '0) || !goIdle;
      bus.alu_in_sel <= 3'b000;

      case (state)
        IDLE: if (pop) begin
          if (head.op == 3'd7) begin
            // reserved opcode never reaches the ALU
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            ovfPend       <= 1'b0;
            state         <= RESP;
          end else begin
            bus.alu_in_sel  <= head.load ? 3'b010 : 3'b100;
            bus.alu_num1    <= head.a;
            bus.alu_num2    <= head.b;
            bus.alu_out_sel <= 7'b1000000 >> head.op;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt <= CW'(ALU_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == '0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.alu_result;
            bus.rsp_err   <= bus.alu_overflow;
            ovfPend       <= bus.alu_overflow;
            state         <= RESP;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          if (ovfPend) begin
            bus.alu_in_sel <= 3'b001;
            state          <= CLR;
          end else begin
            state <= IDLE;
          end
        end
        CLR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized + directed bench for alu_cmd_sequencer with a latency-2
// accumulator ALU model and a command-level response scoreboard.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_if #(.WIDTH(8)) bus ();

  alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {logic [7:0] data; logic err;} exp_t;
  exp_t     expQ[$];
  logic [7:0] refAcc;
  int       checks = 0, errors = 0, rspCnt = 0;
  bit       rndRdy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {overflow, result} of one ALU operation
  function automatic logic [8:0] aluFn(input int op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    case (op)
      0: return {1'b0, x & y};
      1: return {1'b0, x | y};
      2: return {1'b0, ~x};
      3: return {1'b0, x ^ y};
      4: return {1'b0, x} + {1'b0, y};
      5: return {x < y, 8'(x - y)};
      default: begin p = x * y; return {p > 16'd255, p[7:0]}; end
    endcase
  endfunction

  // ALU: result valid exactly ALU_LAT cycles after the issue cycle, junk otherwise
  logic [7:0] acc, pipeR;
  logic       pipeO;
  always @(posedge clk) begin
    logic [8:0] r;
    int op;
    if (bus.alu_in_sel == 3'b010 || bus.alu_in_sel == 3'b100) begin
      op = 6;
      for (int k = 0; k < 7; k++) if (bus.alu_out_sel[6-k]) op = k;
      r = aluFn(op, (bus.alu_in_sel == 3'b010) ? bus.alu_num1 : acc, bus.alu_num2);
      acc   <= r[7:0];
      pipeR <= r[7:0];
      pipeO <= r[8];
    end else begin
      if (bus.alu_in_sel == 3'b001) acc <= 8'h00;
      pipeR <= 8'($urandom);
      pipeO <= 1'($urandom);
    end
    bus.alu_result   <= pipeR;
    bus.alu_overflow <= pipeO;
  end

  // scoreboard: expected responses computed at acceptance, in order
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] r;
    if (rst) begin
      expQ.delete();
      refAcc = 8'h00;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_op == 3'd7) begin
          e.data = 8'h00; e.err = 1'b1;
        end else begin
          r = aluFn(int'(bus.cmd_op), bus.cmd_load ? bus.cmd_a : refAcc, bus.cmd_b);
          e.data = r[7:0]; e.err = r[8];
          refAcc = r[8] ? 8'h00 : r[7:0];
        end
        expQ.push_back(e);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rspCnt++;
        if (expQ.size() == 0) chk("rsp_extra", 1, 0);
        else begin
          e = expQ.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_err", bus.rsp_err, e.err);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rndRdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic driveCmd(input logic [2:0] op, input logic ld, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_load = ld; bus.cmd_a = a; bus.cmd_b = b;
  endtask

  task automatic waitAccept(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic sendCmd(input logic [2:0] op, input logic ld, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    driveCmd(op, ld, a, b);
    waitAccept(200, ok);
    chk("accept_timeout", ok, 1);
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.rsp_valid) done = 1;
    end
    chk("idle_timeout", done, 1);
    step();
  endtask

  initial begin
    bit ok;
    int base;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_load = 0; bus.cmd_a = 0; bus.cmd_b = 0;
    bus.rsp_ready = 0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_in_sel", bus.alu_in_sel, 3'b001);
    step();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_in_sel_after", bus.alu_in_sel, 3'b000);
    chk("rst_num", {bus.alu_num1, bus.alu_num2}, 0);
    chk("rst_out_sel", bus.alu_out_sel, 0);
    chk("rst_busy", bus.busy, 0);
    step();

    // load ADD: issue in T+2, response in T+5
    sendCmd(3'd4, 1'b1, 8'h12, 8'h34);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        chk("add_in_sel", bus.alu_in_sel, 3'b010);
        chk("add_out_sel", bus.alu_out_sel, 7'b0000100);
        chk("add_num1", bus.alu_num1, 8'h12);
      end
      chk("add_rsp_valid", bus.rsp_valid, i >= 5);
    end
    chk("add_data_direct", bus.rsp_data, 8'h46);
    step();
    bus.rsp_ready = 1;
    waitIdle();

    // persist SUB on accumulator 0x46
    sendCmd(3'd5, 1'b0, 8'hAA, 8'h05);
    @(negedge clk); @(negedge clk);
    chk("sub_in_sel", bus.alu_in_sel, 3'b100);
    chk("sub_out_sel", bus.alu_out_sel, 7'b0000010);
    waitIdle();

    // MUL overflow -> one CLR cycle after the handshake
    sendCmd(3'd6, 1'b1, 8'h20, 8'h10);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("mul_in_sel", bus.alu_in_sel, (i == 2) ? 3'b010 : (i == 6) ? 3'b001 : 3'b000);
      if (i == 5) chk("mul_rsp_err", bus.rsp_err, 1);
      if (i == 6) chk("mul_busy_clr", bus.busy, 1);
      if (i == 7) chk("mul_busy_done", bus.busy, 0);
    end
    step();

    // reserved opcode: response in T+2, ALU untouched
    bus.rsp_ready = 0;
    sendCmd(3'd7, 1'b1, 8'h55, 8'h66);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("rsv_rsp_valid", bus.rsp_valid, i >= 2);
      chk("rsv_in_sel", bus.alu_in_sel, 3'b000);
    end
    step();
    bus.rsp_ready = 1;
    waitIdle();

    // backpressure: 4 queued + 1 in flight, 6th must wait
    bus.rsp_ready = 0;
    base = rspCnt;
    for (int k = 0; k < 5; k++)
      sendCmd(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 8'($urandom));
    driveCmd(3'd3, 1'b1, 8'hC3, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("full_cmd_ready", bus.cmd_ready, 0);
    end
    step();
    bus.rsp_ready = 1;
    waitAccept(100, ok);
    chk("sixth_accept", ok, 1);
    waitIdle();
    chk("drain_count", rspCnt - base, 6);

    // reset while in WAIT with two queued
    bus.rsp_ready = 0;
    base = rspCnt;
    sendCmd(3'd4, 1'b1, 8'h01, 8'h02);
    sendCmd(3'd1, 1'b1, 8'h10, 8'h20);
    sendCmd(3'd0, 1'b1, 8'hF0, 8'h3C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.rsp_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    end
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
    chk("rst_mid_rsp_count", rspCnt - base, 0);
    step();

    // randomized traffic with random response backpressure
    rndRdy = 1;
    for (int k = 0; k < 60; k++) begin
      sendCmd(($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
              1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
    end
    rndRdy = 0;
    step();
    bus.rsp_ready = 1;
    waitIdle();
    chk("queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
